seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
Display output stage directly downstream of the MuxStateMach scan sequencer.
- Consumes the 4-bit scan select and drives one of 16 seven-segment digits per scan slot: active-low anode one-hot, hex-decoded segments, decimal point.
- Holds a double-buffered 16-digit display image loaded through a pulse handshake.
- Inserts a ghosting guard (blank interval) on every select change.
- New images become visible only at frame boundaries, so partial frames are never displayed.

Parameters:
BLANK_CYCLES, 2, clock cycles all anodes are held off after each select change (legal 1..15)
NUM_DIGITS, 16, digits scanned; fixed to 16 to match the 4-bit select

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
On  in  1  display enable; same signal that enables the scan sequencer
state  in  4  scan select from the sequencer; digit index 0..15
load  in  1  single-cycle request to capture a new image
load_data  in  64  image; digit k = load_data[4k+3:4k], hex 0..F
load_dp  in  16  decimal-point mask; bit k lights the DP of digit k
load_ack  out  1  1-cycle pulse: the load was captured
busy  out  1  pending image is waiting for a frame boundary
an  out  16  anode drive, active-low, at most one bit low
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
frame_done  out  1  1-cycle pulse when digit 15 starts driving

Behaviour:
Reset (Rst_n low, asynchronous):
- an=16'hFFFF, seg=7'h7F, dp=1, load_ack=0, busy=0, frame_done=0.
- Active and pending buffers cleared to 0; sel_q=0; FSM=IDLE; blank counter=0.
- Reset mid-operation aborts everything immediately, including a pending image, which is lost.

Select capture:
- sel_q <= state every cycle.
- A select change is sel_q != state.

FSM states IDLE, BLANK, DRIVE; registered outputs.
- IDLE: outputs blanked. When On=1, go to BLANK and load the counter with BLANK_CYCLES-1.
- BLANK: an=all-ones, seg=7'h7F, dp=1.
  - Counter decrements each cycle; at 0, go to DRIVE.
  - A select change during BLANK reloads the counter.
- DRIVE:
  - an[sel_q]=0; seg=hex decode of active digit sel_q; dp=~active_dp[sel_q].
  - A select change goes to BLANK with the counter reloaded; the anode is off on the next edge.
- On=0 in any state: go to IDLE next edge, outputs blanked.
- Latency: a select held stable lights its digit BLANK_CYCLES+1 edges after the change appears on state.

Hex decode, active-low {g..a}:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

frame_done:
- Pulses 1 cycle on the edge the FSM enters DRIVE with sel_q=15.
- Does not pulse again until the select leaves 15 and returns.

Load handshake:
- load=1 with busy=0: capture load_data/load_dp into pending; busy=1; load_ack=1 next cycle.
- load=1 with busy=1: ignored; no load_ack; pending unchanged.

Commit:
- Pending is copied to active, and busy cleared, on the frame-boundary edge: sel_q goes 15→any other value, or any value→0.
- With On=0, commit happens on the cycle after capture.

Simultaneous load and commit (busy=1):
- The old pending commits.
- The new load is captured; busy stays 1; load_ack pulses.

Test Plan:
- Reset, then On=1, state held 3, load digit3=0x5, dp3=1, wait for commit via 15→0 → after BLANK_CYCLES+1 edges: an=16'hFFF7, seg=7'h12, dp=0.
- state steps 4→5 while in DRIVE → next edge an=16'hFFFF, seg=7'h7F for exactly 2 cycles; 3rd edge an=16'hFFDF.
- load at state=7 with image A (busy=0) → load_ack 1 cycle, busy=1, old digits still shown; state 15→0 → busy=0; digit 0 of image A is shown.
- Second load while busy=1 → no load_ack; pending stays image A.
- Load coincident with the 15→0 commit → image A active, image B pending, busy=1, load_ack=1.
- Scan full 0..15 → frame_done exactly once, on entering DRIVE at 15. Drop On mid-DRIVE → an=16'hFFFF next edge. Assert Rst_n=0 between edges → outputs at reset values immediately, busy=0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Seven-segment scan output stage: blanks the anodes on every select change and drives the
// selected digit from a double-buffered image that only swaps at frame boundaries.
module seg_scan_driver #(
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned NUM_DIGITS   = 16
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    On,
    input  logic [3:0]              state,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    output logic                    load_ack,
    output logic                    busy,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    typedef enum logic [1:0] {StIdle, StBlank, StDrive} fsm_t;

    localparam logic [3:0] BlankReload = 4'(BLANK_CYCLES - 1);
    localparam logic [3:0] LastSel     = 4'(NUM_DIGITS - 1);
    localparam logic [6:0] SegOff      = 7'h7F;

    fsm_t                    fsm_q;
    logic [3:0]              sel_q;
    logic [3:0]              cnt_q;
    logic                    fd_armed_q;
    logic [4*NUM_DIGITS-1:0] active_data_q;
    logic [NUM_DIGITS-1:0]   active_dp_q;
    logic [4*NUM_DIGITS-1:0] pend_data_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;

    logic                    sel_change;
    logic                    boundary;
    logic                    commit;
    logic                    accept;
    logic [NUM_DIGITS-1:0]   drive_an;
    logic [6:0]              drive_seg;
    logic                    drive_dp;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        sel_change = (sel_q != state);
        // Frame boundary: leaving the last digit, or arriving at digit 0.
        boundary   = ((sel_q == LastSel) && (state != LastSel)) ||
                     ((sel_q != 4'd0) && (state == 4'd0));
        // With the display off there is no frame to tear, so commit right away.
        commit     = busy && (boundary || !On);
        accept     = load && (!busy || commit);
    end

    // Only used on edges where the select is stable, so sel_q equals the incoming select.
    always_comb begin
        drive_an         = '1;
        drive_an[sel_q]  = 1'b0;
        drive_seg        = hex_to_seg(active_data_q[{sel_q, 2'b00} +: 4]);
        drive_dp         = ~active_dp_q[sel_q];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fsm_q      <= StIdle;
            sel_q      <= 4'd0;
            cnt_q      <= 4'd0;
            fd_armed_q <= 1'b1;
            an         <= '1;
            seg        <= SegOff;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            sel_q      <= state;
            frame_done <= 1'b0;
            if (state != LastSel) begin
                fd_armed_q <= 1'b1;
            end
            if (!On) begin
                fsm_q <= StIdle;
                an    <= '1;
                seg   <= SegOff;
                dp    <= 1'b1;
            end else begin
                unique case (fsm_q)
                    StIdle: begin
                        fsm_q <= StBlank;
                        cnt_q <= BlankReload;
                        an    <= '1;
                        seg   <= SegOff;
                        dp    <= 1'b1;
                    end
                    StBlank: begin
                        if (sel_change) begin
                            cnt_q <= BlankReload;
                        end else if (cnt_q == 4'd0) begin
                            fsm_q <= StDrive;
                            an    <= drive_an;
                            seg   <= drive_seg;
                            dp    <= drive_dp;
                            if ((sel_q == LastSel) && fd_armed_q) begin
                                frame_done <= 1'b1;
                                fd_armed_q <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                    StDrive: begin
                        if (sel_change) begin
                            fsm_q <= StBlank;
                            cnt_q <= BlankReload;
                            an    <= '1;
                            seg   <= SegOff;
                            dp    <= 1'b1;
                        end else begin
                            an    <= drive_an;
                            seg   <= drive_seg;
                            dp    <= drive_dp;
                        end
                    end
                    default: begin
                        fsm_q <= StIdle;
                        an    <= '1;
                        seg   <= SegOff;
                        dp    <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            active_data_q <= '0;
            active_dp_q   <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            busy          <= 1'b0;
            load_ack      <= 1'b0;
        end else begin
            load_ack <= accept;
            busy     <= accept | (busy & ~commit);
            if (commit) begin
                active_data_q <= pend_data_q;
                active_dp_q   <= pend_dp_q;
            end
            // A load on the commit edge lands behind the image being committed.
            if (accept) begin
                pend_data_q <= load_data;
                pend_dp_q   <= load_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: image model plus a queue of expected digit displays.
module tb_seg_scan_driver;

    localparam int unsigned BLANK = 2;

    localparam logic [63:0] IMG_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [15:0] DP_A  = 16'hA5A5;
    localparam logic [63:0] IMG_B = 64'h8BAD_F00D_DEAD_BEEF;
    localparam logic [15:0] DP_B  = 16'h0F0F;
    localparam logic [63:0] IMG_C = 64'h1122_3344_5566_7788;
    localparam logic [15:0] DP_C  = 16'h3C3C;
    localparam logic [63:0] IMG_D = 64'hC0FF_EE00_1234_ABCD;
    localparam logic [15:0] DP_D  = 16'h8001;
    localparam logic [63:0] IMG_E = 64'h7777_7777_7777_7777;
    localparam logic [15:0] DP_E  = 16'hFFFF;

    logic        Clk;
    logic        Rst_n;
    logic        On;
    logic [3:0]  state;
    logic        load;
    logic [63:0] load_data;
    logic [15:0] load_dp;
    logic        load_ack;
    logic        busy;
    logic [15:0] an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    logic [63:0] m_active;
    logic [15:0] m_adp;
    logic [63:0] m_pend;
    logic [15:0] m_pdp;
    logic        m_busy;
    logic [3:0]  cur_state;
    logic [23:0] exp_q[$];

    int          total = 0;
    int          bad = 0;
    int          fd_count = 0;
    logic [15:0] fd_an = 16'h0000;

    seg_scan_driver #(
        .BLANK_CYCLES(BLANK),
        .NUM_DIGITS  (16)
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .On        (On),
        .state     (state),
        .load      (load),
        .load_data (load_data),
        .load_dp   (load_dp),
        .load_ack  (load_ack),
        .busy      (busy),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (frame_done === 1'b1) begin
            fd_count = fd_count + 1;
            fd_an    = an;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [23:0] expect_of(input logic [3:0] s);
        logic [15:0] a;
        int          idx;
        a    = 16'hFFFF;
        a[s] = 1'b0;
        idx  = int'(s) * 4;
        return {a, seg_of(m_active[idx +: 4]), ~m_adp[s]};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Move the select to s, expect the new digit after the blanking interval.
    task automatic show_digit(input logic [3:0] s);
        logic [23:0] want;
        logic [23:0] got;
        int          edges;
        logic        chg;
        chg = (s != cur_state);
        if (m_busy && (((cur_state == 4'd15) && (s != 4'd15)) ||
                       ((cur_state != 4'd0) && (s == 4'd0)))) begin
            m_active = m_pend;
            m_adp    = m_pdp;
            m_busy   = 1'b0;
        end
        state     = s;
        cur_state = s;
        exp_q.push_back(expect_of(s));
        edges = 0;
        do begin
            tick();
            edges++;
        end while ((an === 16'hFFFF) && (edges < 20));
        got  = {an, seg, dp};
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL show_digit[%0d] {an,seg,dp}: got %h want %h", s, got, want);
        end
        if (chg) begin
            total++;
            if (edges != BLANK + 1) begin
                bad++;
                $display("FAIL latency[%0d]: got %0d edges want %0d", s, edges, BLANK + 1);
            end
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; On = 1'b0; state = 4'd0; load = 1'b0;
        load_data = '0; load_dp = '0;
        m_active = '0; m_adp = '0; m_pend = '0; m_pdp = '0; m_busy = 1'b0;
        cur_state = 4'd0;
        tick();
        tick();
        total += 6;
        if (an !== 16'hFFFF) begin bad++; $display("FAIL reset_an: got %h want ffff", an); end
        if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %h want 7f", seg); end
        if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp: got %b want 1", dp); end
        if (load_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", load_ack); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (frame_done !== 1'b0) begin
            bad++; $display("FAIL reset_fd: got %b want 0", frame_done);
        end
        Rst_n = 1'b1;
    endtask

    task automatic test_first_digit();
        On = 1'b1; state = 4'd3; cur_state = 4'd3;
        load = 1'b1; load_data = 64'h5 << 12; load_dp = 16'h0008;
        tick();
        m_pend = 64'h5 << 12; m_pdp = 16'h0008; m_busy = 1'b1;
        load = 1'b0;
        total += 2;
        if (load_ack !== 1'b1) begin bad++; $display("FAIL first_ack: got %b want 1", load_ack); end
        if (busy !== 1'b1) begin bad++; $display("FAIL first_busy: got %b want 1", busy); end
        tick();
        total++;
        if (load_ack !== 1'b0) begin bad++; $display("FAIL first_ack_pulse: got %b want 0", load_ack); end
        show_digit(4'd15);
        show_digit(4'd0);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL first_commit_busy: got %b want 0", busy); end
        show_digit(4'd3);
    endtask

    task automatic test_step_blank();
        show_digit(4'd4);
        state = 4'd5; cur_state = 4'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({an, seg} !== {16'hFFFF, 7'h7F}) begin
                bad++; $display("FAIL step_blank[%0d]: got %h/%h want ffff/7f", i, an, seg);
            end
        end
        tick();
        total++;
        if ({an, seg} !== {16'hFFDF, seg_of(m_active[23:20])}) begin
            bad++;
            $display("FAIL step_lit: got %h/%h want ffdf/%h", an, seg, seg_of(m_active[23:20]));
        end
    endtask

    task automatic test_load_busy();
        show_digit(4'd7);
        load = 1'b1; load_data = IMG_A; load_dp = DP_A;
        tick();
        m_pend = IMG_A; m_pdp = DP_A; m_busy = 1'b1;
        load = 1'b0;
        total += 2;
        if (load_ack !== 1'b1) begin bad++; $display("FAIL loadA_ack: got %b want 1", load_ack); end
        if (busy !== 1'b1) begin bad++; $display("FAIL loadA_busy: got %b want 1", busy); end
        tick();
        total += 2;
        if (load_ack !== 1'b0) begin bad++; $display("FAIL loadA_ack_pulse: got %b want 0", load_ack); end
        if ({an, seg, dp} !== expect_of(4'd7)) begin
            bad++; $display("FAIL loadA_old_shown: got %h want %h", {an, seg, dp}, expect_of(4'd7));
        end
    endtask

    task automatic test_load_ignored();
        load = 1'b1; load_data = IMG_B; load_dp = DP_B;
        tick();
        load = 1'b0;
        total += 2;
        if (load_ack !== 1'b0) begin bad++; $display("FAIL ignored_ack: got %b want 0", load_ack); end
        if (busy !== 1'b1) begin bad++; $display("FAIL ignored_busy: got %b want 1", busy); end
        tick();
        show_digit(4'd15);
        show_digit(4'd0);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL commitA_busy: got %b want 0", busy); end
        show_digit(4'd10);
    endtask

    task automatic test_load_commit();
        logic [23:0] want;
        int          edges;
        show_digit(4'd15);
        load = 1'b1; load_data = IMG_C; load_dp = DP_C;
        tick();
        m_pend = IMG_C; m_pdp = DP_C; m_busy = 1'b1;
        total++;
        if (load_ack !== 1'b1) begin bad++; $display("FAIL loadC_ack: got %b want 1", load_ack); end
        // Load B on the same edge that commits C.
        state = 4'd0; cur_state = 4'd0;
        load_data = IMG_B; load_dp = DP_B;
        m_active = m_pend; m_adp = m_pdp;
        m_pend = IMG_B; m_pdp = DP_B;
        exp_q.push_back(expect_of(4'd0));
        tick();
        load = 1'b0;
        edges = 1;
        total += 2;
        if (load_ack !== 1'b1) begin bad++; $display("FAIL coinc_ack: got %b want 1", load_ack); end
        if (busy !== 1'b1) begin bad++; $display("FAIL coinc_busy: got %b want 1", busy); end
        while ((an === 16'hFFFF) && (edges < 20)) begin
            tick();
            edges++;
        end
        want = exp_q.pop_front();
        total += 2;
        if ({an, seg, dp} !== want) begin
            bad++; $display("FAIL coinc_shown: got %h want %h", {an, seg, dp}, want);
        end
        if (edges != BLANK + 1) begin
            bad++; $display("FAIL coinc_latency: got %0d edges want %0d", edges, BLANK + 1);
        end
        show_digit(4'd15);
        show_digit(4'd0);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL commitB_busy: got %b want 0", busy); end
    endtask

    task automatic test_frame_done();
        int base;
        show_digit(4'd1);
        base = fd_count;
        for (int s = 0; s < 16; s++) begin
            show_digit(4'(s));
        end
        repeat (5) tick();
        total += 2;
        if (fd_count - base != 1) begin
            bad++; $display("FAIL fd_count: got %0d want 1", fd_count - base);
        end
        if (fd_an !== 16'h7FFF) begin bad++; $display("FAIL fd_an: got %h want 7fff", fd_an); end
    endtask

    task automatic test_on_drop();
        logic [23:0] want;
        int          edges;
        int          base;
        On = 1'b0;
        tick();
        total++;
        if ({an, seg, dp} !== {16'hFFFF, 7'h7F, 1'b1}) begin
            bad++; $display("FAIL on_drop: got %h want ffff7f1", {an, seg, dp});
        end
        load = 1'b1; load_data = IMG_D; load_dp = DP_D;
        tick();
        load = 1'b0;
        total += 2;
        if (load_ack !== 1'b1) begin bad++; $display("FAIL off_ack: got %b want 1", load_ack); end
        if (busy !== 1'b1) begin bad++; $display("FAIL off_busy: got %b want 1", busy); end
        tick();
        m_active = IMG_D; m_adp = DP_D;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL off_commit: got %b want 0", busy); end
        base = fd_count;
        On = 1'b1;
        exp_q.push_back(expect_of(4'd15));
        edges = 0;
        do begin
            tick();
            edges++;
        end while ((an === 16'hFFFF) && (edges < 20));
        want = exp_q.pop_front();
        total += 3;
        if ({an, seg, dp} !== want) begin
            bad++; $display("FAIL on_resume: got %h want %h", {an, seg, dp}, want);
        end
        if (edges != BLANK + 1) begin
            bad++; $display("FAIL on_latency: got %0d edges want %0d", edges, BLANK + 1);
        end
        if (fd_count != base) begin
            bad++; $display("FAIL fd_rearm: got %0d extra pulses want 0", fd_count - base);
        end
    endtask

    task automatic test_reset_async();
        load = 1'b1; load_data = IMG_E; load_dp = DP_E;
        tick();
        load = 1'b0;
        total += 2;
        if (load_ack !== 1'b1) begin bad++; $display("FAIL loadE_ack: got %b want 1", load_ack); end
        if (busy !== 1'b1) begin bad++; $display("FAIL loadE_busy: got %b want 1", busy); end
        #2;
        Rst_n = 1'b0;
        #1;
        total += 5;
        if (an !== 16'hFFFF) begin bad++; $display("FAIL arst_an: got %h want ffff", an); end
        if (seg !== 7'h7F) begin bad++; $display("FAIL arst_seg: got %h want 7f", seg); end
        if (dp !== 1'b1) begin bad++; $display("FAIL arst_dp: got %b want 1", dp); end
        if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b want 0", busy); end
        if (load_ack !== 1'b0) begin bad++; $display("FAIL arst_ack: got %b want 0", load_ack); end
        m_active = '0; m_adp = '0; m_pend = '0; m_pdp = '0; m_busy = 1'b0;
        cur_state = 4'd0;
        #1;
        Rst_n = 1'b1;
        show_digit(4'd3);
        show_digit(4'd15);
        show_digit(4'd0);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL arst_lost_pending: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_first_digit();
        test_step_blank();
        test_load_busy();
        test_load_ignored();
        test_load_commit();
        test_frame_done();
        test_on_drop();
        test_reset_async();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
